// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IFU, LSU and memory bus signals
// grouped for the shared memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            ifu_req;
  logic [AW-1:0]   ifu_addr;
  logic            ifu_done;
  logic [DW-1:0]   ifu_rdata;
  logic            lsu_read;
  logic            lsu_write;
  logic [AW-1:0]   lsu_addr;
  logic [DW-1:0]   lsu_wdata;
  logic [DW/8-1:0] lsu_byteen;
  logic            lsu_done;
  logic [DW-1:0]   lsu_rdata;
  logic            lsu_stall;
  logic            bus_read;
  logic            bus_write;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic [DW/8-1:0] bus_byteen;
  logic            bus_waitrequest;
  logic            bus_rvalid;
  logic [DW-1:0]   bus_rdata;

  modport master (
    input  ifu_req, ifu_addr,
    output ifu_done, ifu_rdata,
    input  lsu_read, lsu_write, lsu_addr,
    input  lsu_wdata, lsu_byteen,
    output lsu_done, lsu_rdata, lsu_stall,
    output bus_read, bus_write, bus_addr,
    output bus_wdata, bus_byteen,
    input  bus_waitrequest, bus_rvalid, bus_rdata
  );

  modport slave (
    output ifu_req, ifu_addr,
    input  ifu_done, ifu_rdata,
    output lsu_read, lsu_write, lsu_addr,
    output lsu_wdata, lsu_byteen,
    input  lsu_done, lsu_rdata, lsu_stall,
    input  bus_read, bus_write, bus_addr,
    input  bus_wdata, bus_byteen,
    output bus_waitrequest, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between IFU and LSU,
// one transaction at a time, LSU has fixed priority.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master io
);
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RESP
  } state_t;

  state_t          state;
  logic            owner_lsu;
  logic            rd_q;
  logic            wr_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [BW-1:0]   byteen_q;
  logic            lsu_req;
  logic            xfer_done;

  assign lsu_req = io.lsu_read | io.lsu_write;

  // Writes finish on command accept, reads on returned data.
  assign xfer_done = ~rst &
    (((state == CMD) & wr_q & ~io.bus_waitrequest) |
     ((state == RESP) & io.bus_rvalid));

  assign io.ifu_done  = xfer_done & ~owner_lsu;
  assign io.lsu_done  = xfer_done & owner_lsu;
  assign io.ifu_rdata = io.bus_rdata;
  assign io.lsu_rdata = io.bus_rdata;
  assign io.lsu_stall = lsu_req & ~io.lsu_done;

  assign io.bus_read   = rd_q;
  assign io.bus_write  = wr_q;
  assign io.bus_addr   = addr_q;
  assign io.bus_wdata  = wdata_q;
  assign io.bus_byteen = byteen_q;

  // Grant, command hold and response wait; all bus outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_lsu <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      byteen_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (lsu_req) begin
            owner_lsu <= 1'b1;
            addr_q    <= io.lsu_addr;
            wdata_q   <= io.lsu_wdata;
            byteen_q  <= io.lsu_write ? io.lsu_byteen : '1;
            wr_q      <= io.lsu_write;
            rd_q      <= ~io.lsu_write;
            state     <= CMD;
          end else if (io.ifu_req) begin
            owner_lsu <= 1'b0;
            addr_q    <= io.ifu_addr;
            byteen_q  <= '1;
            wr_q      <= 1'b0;
            rd_q      <= 1'b1;
            state     <= CMD;
          end
        end
        CMD: begin
          if (!io.bus_waitrequest) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            state <= wr_q ? IDLE : RESP;
          end
        end
        RESP: begin
          if (io.bus_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios for the
// shared memory port arbiter.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) b();

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk),
    .rst(rst),
    .io (b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    b.ifu_req = 0; b.ifu_addr = '0;
    b.lsu_read = 0; b.lsu_write = 0;
    b.lsu_addr = '0; b.lsu_wdata = '0;
    b.lsu_byteen = '0;
    b.bus_waitrequest = 0;
    b.bus_rvalid = 0; b.bus_rdata = '0;
  endtask

  task automatic test_reset;
    rst = 1; idle_inputs();
    tick(); tick(); #1;
    n_chk++;
    if ({b.bus_read, b.bus_write} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_cmd: got %b exp 00",
        {b.bus_read, b.bus_write});
    end
    n_chk++;
    if ({b.bus_addr, b.bus_wdata, b.bus_byteen} !== '0) begin
      n_fail++;
      $display("FAIL rst_bus: addr %h wdata %h be %h exp 0",
        b.bus_addr, b.bus_wdata, b.bus_byteen);
    end
    n_chk++;
    if ({b.ifu_done, b.lsu_done, b.lsu_stall} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_done: got %b exp 000",
        {b.ifu_done, b.lsu_done, b.lsu_stall});
    end
    b.lsu_read = 1; #1;
    n_chk++;
    if (b.lsu_stall !== 1'b1 || b.lsu_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stall: stall %b done %b exp 1 0",
        b.lsu_stall, b.lsu_done);
    end
    b.lsu_read = 0; rst = 0;
    tick();
  endtask

  task automatic test_write;
    b.lsu_write = 1; b.lsu_addr = 32'h100;
    b.lsu_wdata = 32'hDEADBEEF; b.lsu_byteen = 4'hF;
    #1;
    n_chk++;
    if (b.lsu_stall !== 1'b1 || b.bus_write !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_c0: stall %b bus_write %b exp 1 0",
        b.lsu_stall, b.bus_write);
    end
    tick(); #1;
    n_chk++;
    if (b.bus_write !== 1 || b.bus_read !== 0 ||
        b.bus_addr !== 32'h100 || b.bus_wdata !== 32'hDEADBEEF ||
        b.bus_byteen !== 4'hF) begin
      n_fail++;
      $display("FAIL wr_cmd: w %b r %b a %h d %h be %h",
        b.bus_write, b.bus_read, b.bus_addr, b.bus_wdata,
        b.bus_byteen);
    end
    n_chk++;
    if (b.lsu_done !== 1 || b.ifu_done !== 0 || b.lsu_stall !== 0) begin
      n_fail++;
      $display("FAIL wr_done: lsu %b ifu %b stall %b exp 1 0 0",
        b.lsu_done, b.ifu_done, b.lsu_stall);
    end
    tick();
    b.lsu_addr = 32'h104; b.lsu_wdata = 32'h01020304;
    b.lsu_byteen = 4'h3; b.bus_waitrequest = 1;
    #1;
    n_chk++;
    if (b.bus_write !== 0 || b.lsu_done !== 0 || b.lsu_stall !== 1) begin
      n_fail++;
      $display("FAIL b2b_idle: w %b done %b stall %b exp 0 0 1",
        b.bus_write, b.lsu_done, b.lsu_stall);
    end
    tick(); #1;
    n_chk++;
    if (b.bus_write !== 1 || b.bus_addr !== 32'h104 ||
        b.bus_byteen !== 4'h3 || b.lsu_done !== 0) begin
      n_fail++;
      $display("FAIL b2b_wait: w %b a %h be %h done %b",
        b.bus_write, b.bus_addr, b.bus_byteen, b.lsu_done);
    end
    tick(); b.bus_waitrequest = 0; #1;
    n_chk++;
    if (b.bus_write !== 1 || b.bus_wdata !== 32'h01020304 ||
        b.lsu_done !== 1) begin
      n_fail++;
      $display("FAIL b2b_done: w %b d %h done %b",
        b.bus_write, b.bus_wdata, b.lsu_done);
    end
    tick(); idle_inputs(); #1;
    n_chk++;
    if (b.bus_write !== 0 || b.lsu_done !== 0) begin
      n_fail++;
      $display("FAIL wr_end: w %b done %b exp 0 0",
        b.bus_write, b.lsu_done);
    end
    tick();
  endtask

  task automatic test_ifu_wait;
    b.ifu_req = 1; b.ifu_addr = 32'h40; b.bus_waitrequest = 1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) b.bus_waitrequest = 0;
      #1;
      n_chk++;
      if (b.bus_read !== 1 || b.bus_addr !== 32'h40 ||
          b.bus_byteen !== 4'hF || b.ifu_done !== 0) begin
        n_fail++;
        $display("FAIL ifu_hold c%0d: r %b a %h be %h done %b",
          c, b.bus_read, b.bus_addr, b.bus_byteen, b.ifu_done);
      end
    end
    tick(); #1;
    n_chk++;
    if (b.bus_read !== 0 || b.ifu_done !== 0) begin
      n_fail++;
      $display("FAIL ifu_resp: r %b done %b exp 0 0",
        b.bus_read, b.ifu_done);
    end
    tick(); b.bus_rvalid = 1; b.bus_rdata = 32'h13; #1;
    n_chk++;
    if (b.ifu_done !== 1 || b.ifu_rdata !== 32'h13 ||
        b.lsu_done !== 0) begin
      n_fail++;
      $display("FAIL ifu_done: done %b rdata %h lsu %b",
        b.ifu_done, b.ifu_rdata, b.lsu_done);
    end
    tick(); idle_inputs(); #1;
    n_chk++;
    if (b.ifu_done !== 0 || b.bus_read !== 0) begin
      n_fail++;
      $display("FAIL ifu_end: done %b r %b exp 0 0",
        b.ifu_done, b.bus_read);
    end
    tick();
  endtask

  task automatic test_priority;
    b.ifu_req = 1; b.ifu_addr = 32'h80;
    b.lsu_read = 1; b.lsu_addr = 32'h200;
    tick(); #1;
    n_chk++;
    if (b.bus_read !== 1 || b.bus_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL pri_grant: r %b a %h exp 1 00000200",
        b.bus_read, b.bus_addr);
    end
    tick(); b.bus_rvalid = 1; b.bus_rdata = 32'hAAAA5555; #1;
    n_chk++;
    if (b.lsu_done !== 1 || b.ifu_done !== 0 ||
        b.lsu_rdata !== 32'hAAAA5555) begin
      n_fail++;
      $display("FAIL pri_lsu: lsu %b ifu %b rdata %h",
        b.lsu_done, b.ifu_done, b.lsu_rdata);
    end
    tick(); b.lsu_read = 0; b.bus_rvalid = 0; #1;
    n_chk++;
    if (b.bus_read !== 0 || b.ifu_done !== 0) begin
      n_fail++;
      $display("FAIL pri_idle: r %b ifu %b exp 0 0",
        b.bus_read, b.ifu_done);
    end
    tick(); #1;
    n_chk++;
    if (b.bus_read !== 1 || b.bus_addr !== 32'h80) begin
      n_fail++;
      $display("FAIL pri_ifu: r %b a %h exp 1 00000080",
        b.bus_read, b.bus_addr);
    end
    tick(); b.bus_rvalid = 1; b.bus_rdata = 32'h1234; #1;
    n_chk++;
    if (b.ifu_done !== 1 || b.lsu_done !== 0 ||
        b.ifu_rdata !== 32'h1234) begin
      n_fail++;
      $display("FAIL pri_ifu_done: ifu %b lsu %b rdata %h",
        b.ifu_done, b.lsu_done, b.ifu_rdata);
    end
    tick(); idle_inputs(); tick();
  endtask

  task automatic test_lsu_during_resp;
    b.ifu_req = 1; b.ifu_addr = 32'h44;
    tick(); tick();
    b.lsu_read = 1; b.lsu_addr = 32'h300; #1;
    n_chk++;
    if (b.lsu_stall !== 1 || b.bus_read !== 0) begin
      n_fail++;
      $display("FAIL mix_resp: stall %b r %b exp 1 0",
        b.lsu_stall, b.bus_read);
    end
    tick(); b.bus_rvalid = 1; b.bus_rdata = 32'h55; #1;
    n_chk++;
    if (b.ifu_done !== 1 || b.lsu_done !== 0 || b.lsu_stall !== 1) begin
      n_fail++;
      $display("FAIL mix_ifu: ifu %b lsu %b stall %b exp 1 0 1",
        b.ifu_done, b.lsu_done, b.lsu_stall);
    end
    tick(); b.ifu_req = 0; b.bus_rvalid = 0; #1;
    n_chk++;
    if (b.lsu_stall !== 1 || b.bus_read !== 0) begin
      n_fail++;
      $display("FAIL mix_idle: stall %b r %b exp 1 0",
        b.lsu_stall, b.bus_read);
    end
    tick(); #1;
    n_chk++;
    if (b.bus_read !== 1 || b.bus_addr !== 32'h300 ||
        b.lsu_stall !== 1) begin
      n_fail++;
      $display("FAIL mix_cmd: r %b a %h stall %b",
        b.bus_read, b.bus_addr, b.lsu_stall);
    end
    tick(); b.bus_rvalid = 1; b.bus_rdata = 32'h66; #1;
    n_chk++;
    if (b.lsu_done !== 1 || b.ifu_done !== 0 ||
        b.lsu_rdata !== 32'h66 || b.lsu_stall !== 0) begin
      n_fail++;
      $display("FAIL mix_lsu: lsu %b ifu %b rdata %h stall %b",
        b.lsu_done, b.ifu_done, b.lsu_rdata, b.lsu_stall);
    end
    tick(); idle_inputs(); tick();
  endtask

  task automatic test_flush;
    int pulses = 0;
    b.ifu_req = 1; b.ifu_addr = 32'h48; b.bus_waitrequest = 1;
    tick(); b.ifu_req = 0; #1;
    n_chk++;
    if (b.bus_read !== 1 || b.bus_addr !== 32'h48) begin
      n_fail++;
      $display("FAIL fl_cmd: r %b a %h exp 1 00000048",
        b.bus_read, b.bus_addr);
    end
    tick(); b.bus_waitrequest = 0; #1;
    n_chk++;
    if (b.bus_read !== 1) begin
      n_fail++;
      $display("FAIL fl_hold: r %b exp 1", b.bus_read);
    end
    tick(); b.bus_rvalid = 1; b.bus_rdata = 32'h99; #1;
    if (b.ifu_done === 1) pulses++;
    tick(); b.bus_rvalid = 0; #1;
    if (b.ifu_done === 1) pulses++;
    tick(); #1;
    if (b.ifu_done === 1) pulses++;
    n_chk++;
    if (pulses != 1 || b.bus_read !== 0) begin
      n_fail++;
      $display("FAIL fl_done: pulses %0d r %b exp 1 0",
        pulses, b.bus_read);
    end
    idle_inputs(); tick();
  endtask

  task automatic test_reset_in_resp;
    b.lsu_read = 1; b.lsu_addr = 32'h400;
    tick(); tick();
    rst = 1; b.lsu_read = 0; #1;
    n_chk++;
    if (b.lsu_done !== 0 || b.ifu_done !== 0) begin
      n_fail++;
      $display("FAIL rr_rst: lsu %b ifu %b exp 0 0",
        b.lsu_done, b.ifu_done);
    end
    tick(); rst = 0;
    b.bus_rvalid = 1; b.bus_rdata = 32'h77; #1;
    n_chk++;
    if (b.lsu_done !== 0 || b.ifu_done !== 0 ||
        b.bus_read !== 0 || b.bus_addr !== '0) begin
      n_fail++;
      $display("FAIL rr_late: lsu %b ifu %b r %b a %h",
        b.lsu_done, b.ifu_done, b.bus_read, b.bus_addr);
    end
    tick(); b.bus_rvalid = 0;
    b.lsu_read = 1; b.lsu_addr = 32'h500;
    tick(); #1;
    n_chk++;
    if (b.bus_read !== 1 || b.bus_addr !== 32'h500) begin
      n_fail++;
      $display("FAIL rr_next: r %b a %h exp 1 00000500",
        b.bus_read, b.bus_addr);
    end
    tick(); b.bus_rvalid = 1; b.bus_rdata = 32'h88; #1;
    n_chk++;
    if (b.lsu_done !== 1 || b.lsu_rdata !== 32'h88) begin
      n_fail++;
      $display("FAIL rr_done: lsu %b rdata %h exp 1 00000088",
        b.lsu_done, b.lsu_rdata);
    end
    tick(); idle_inputs(); tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write();
    test_ifu_wait();
    test_priority();
    test_lsu_during_resp();
    test_flush();
    test_reset_in_resp();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end
endmodule
